stone_renderer: RTL and testbench



---
 rtl/stone_pkg.sv | 52 +++++
 rtl/sprite_scanner.sv | 44 ++++
 rtl/stone_renderer.sv | 238 +++++++++++++++++++++++
 tb/tb_stone_renderer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stone_pkg.sv
// Shared definitions for the stone RAM readers: word field layout, item type
// codes, per-type colours, default screen size and the renderer state set.
package stone_pkg;

  localparam int X_MSB    = 31;
  localparam int X_LSB    = 23;
  localparam int Y_MSB    = 18;
  localparam int Y_LSB    = 11;
  localparam int TYPE_MSB = 3;
  localparam int TYPE_LSB = 2;
  localparam int VIS_BIT  = 1;
  localparam int MOV_BIT  = 0;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef enum logic [1:0] {
    TYPE_STONE   = 2'b00,
    TYPE_GOLD    = 2'b01,
    TYPE_DIAMOND = 2'b10,
    TYPE_OTHER   = 2'b11
  } stone_type_e;

  localparam logic [2:0] COLOUR_STONE     = 3'b111;
  localparam logic [2:0] COLOUR_GOLD      = 3'b110;
  localparam logic [2:0] COLOUR_DIAMOND   = 3'b011;
  localparam logic [2:0] COLOUR_OTHER     = 3'b101;
  localparam logic [2:0] COLOUR_HIGHLIGHT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LATCH,
    S_DRAW,
    S_NEXT,
    S_FIN
  } render_state_e;

  // Maps an item type onto the RGB colour used to fill its square.
  function automatic logic [2:0] typeColour(input stone_type_e t);
    logic [2:0] c;
    case (t)
      TYPE_STONE:   c = COLOUR_STONE;
      TYPE_GOLD:    c = COLOUR_GOLD;
      TYPE_DIAMOND: c = COLOUR_DIAMOND;
      default:      c = COLOUR_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_scanner.sv
// Square sprite pixel walker shared by the stone renderer and the rope drawer.
// Steps px fastest, then py, over a SIZE x SIZE square; o_last marks the
// final pixel so the owner can leave its draw state on that cycle.
module sprite_scanner #(
  parameter int SIZE = 16,
  parameter int CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_px,
  output logic [CW-1:0] o_py,
  output logic          o_last
);

  localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

  logic [CW-1:0] r_px;
  logic [CW-1:0] r_py;

  // Raster counter: clear wins over enable; px wraps into a py step.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_clear) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_enable) begin
      if (r_px == MAX) begin
        r_px <= '0;
        r_py <= (r_py == MAX) ? '0 : r_py + 1'b1;
      end else begin
        r_px <= r_px + 1'b1;
      end
    end
  end

  assign o_px   = r_px;
  assign o_py   = r_py;
  assign o_last = (r_px == MAX) && (r_py == MAX);

endmodule

// File: rtl/stone_renderer.sv
// Stone renderer: on start, scans stone RAM entries 0..quantity-1 through the
// shared read port and paints every visible item as a filled square on the
// VGA adapter pixel interface, clipping pixels that fall off screen.
// Optional build macro MOVING_HIGHLIGHT_EN: moving items get a red outline.
module stone_renderer
  import stone_pkg::*;
#(
  parameter int SPRITE_SIZE = 16,
  parameter int RD_LATENCY  = 2,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] data,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        done
);

  localparam int CW = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
  localparam int WW = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;

  render_state_e r_state;
  render_state_e w_nextState;

  logic [3:0]    r_qty;
  logic [3:0]    r_index;
  logic [WW-1:0] r_wait;
  logic [8:0]    r_xBase;
  logic [7:0]    r_yBase;
  stone_type_e   r_type;

  logic          r_flag;
  logic          r_done;
  logic          r_plot;
  logic [8:0]    r_x;
  logic [7:0]    r_y;
  logic [2:0]    r_colour;

  logic          w_scanClear;
  logic          w_scanEnable;
  logic [CW-1:0] w_px;
  logic [CW-1:0] w_py;
  logic          w_last;
  logic          w_lastItem;
  logic          w_waitDone;
  logic [9:0]    w_xSum;
  logic [9:0]    w_ySum;
  logic          w_inBounds;
  logic [2:0]    w_pixColour;
  logic          w_unusedData;

`ifdef MOVING_HIGHLIGHT_EN
  logic          r_moving;
  logic          w_border;
  assign w_unusedData = ^{data[22:19], data[10:4]};
`else
  assign w_unusedData = ^{data[22:19], data[10:4], data[MOV_BIT]};
`endif

  sprite_scanner #(
    .SIZE (SPRITE_SIZE),
    .CW   (CW)
  ) u_scanner (
    .clock    (clock),
    .resetn   (resetn),
    .i_clear  (w_scanClear),
    .i_enable (w_scanEnable),
    .o_px     (w_px),
    .o_py     (w_py),
    .o_last   (w_last)
  );

  assign w_lastItem = (r_index == r_qty - 4'd1);
  assign w_waitDone = (r_wait == WW'(RD_LATENCY - 2));

  // Screen coordinates are formed one bit wider than the port so that an
  // overflow past the right/bottom edge is still seen by the clip compare.
  assign w_xSum     = 10'(r_xBase) + 10'(w_px);
  assign w_ySum     = 10'(r_yBase) + 10'(w_py);
  assign w_inBounds = (w_xSum < 10'(SCREEN_W)) && (w_ySum < 10'(SCREEN_H));

`ifdef MOVING_HIGHLIGHT_EN
  assign w_border = (w_px == '0) || (w_py == '0) ||
                    (w_px == CW'(SPRITE_SIZE - 1)) || (w_py == CW'(SPRITE_SIZE - 1));
`endif

  // Pixel colour: type colour, overridden on the outline of moving items
  // when the highlight feature is built in.
  always_comb begin
    w_pixColour = typeColour(r_type);
`ifdef MOVING_HIGHLIGHT_EN
    if (r_moving && w_border) begin
      w_pixColour = COLOUR_HIGHLIGHT;
    end
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus scanner control for the current state.
  always_comb begin
    w_nextState  = r_state;
    w_scanClear  = 1'b0;
    w_scanEnable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextState = (quantity == 4'd0) ? S_FIN : S_ADDR;
        end
      end
      S_ADDR: begin
        w_nextState = (RD_LATENCY > 1) ? S_WAIT : S_LATCH;
      end
      S_WAIT: begin
        if (w_waitDone) begin
          w_nextState = S_LATCH;
        end
      end
      S_LATCH: begin
        w_scanClear = 1'b1;
        w_nextState = data[VIS_BIT] ? S_DRAW : S_NEXT;
      end
      S_DRAW: begin
        w_scanEnable = 1'b1;
        if (w_last) begin
          w_nextState = S_NEXT;
        end
      end
      S_NEXT: begin
        w_nextState = w_lastItem ? S_FIN : S_ADDR;
      end
      S_FIN: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Scan bookkeeping: frame length, RAM index, read wait and item fields.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_qty   <= '0;
      r_index <= '0;
      r_wait  <= '0;
      r_xBase <= '0;
      r_yBase <= '0;
      r_type  <= TYPE_STONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_qty   <= quantity;
            r_index <= '0;
          end
        end
        S_ADDR: begin
          r_wait <= '0;
        end
        S_WAIT: begin
          r_wait <= r_wait + 1'b1;
        end
        S_LATCH: begin
          r_xBase <= data[X_MSB:X_LSB];
          r_yBase <= data[Y_MSB:Y_LSB];
          r_type  <= stone_type_e'(data[TYPE_MSB:TYPE_LSB]);
        end
        S_NEXT: begin
          if (!w_lastItem) begin
            r_index <= r_index + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MOVING_HIGHLIGHT_EN
  // Moving bit is kept alongside the other item fields for the outline.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_moving <= 1'b0;
    end else if (r_state == S_LATCH) begin
      r_moving <= data[MOV_BIT];
    end
  end
`endif

  // Registered outputs: flag and done follow the upcoming state so they line
  // up with it; the pixel bundle is captured together with its plot strobe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_flag   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      r_flag <= (w_nextState == S_ADDR)  || (w_nextState == S_WAIT) ||
                (w_nextState == S_LATCH) || (w_nextState == S_DRAW) ||
                (w_nextState == S_NEXT);
      r_done <= (w_nextState == S_FIN);
      r_plot <= (r_state == S_DRAW) && w_inBounds;
      if (r_state == S_DRAW) begin
        r_x      <= w_xSum[8:0];
        r_y      <= w_ySum[7:0];
        r_colour <= w_pixColour;
      end
    end
  end

  assign draw_stone_flag = r_flag;
  assign draw_index      = r_index;
  assign x               = r_x;
  assign y               = r_y;
  assign colour          = r_colour;
  assign plot            = r_plot;
  assign done            = r_done;

endmodule

// File: tb/tb_stone_renderer.sv
// Testbench for stone_renderer: a RAM model with two-cycle read latency feeds
// the renderer; a frame-level model pushes the expected pixel stream and
// per-frame facts into queues, and a monitor compares them as the DUT emits.
module tb_stone_renderer;

  localparam int SZ  = 16;
  localparam int RDL = 2;
  localparam int SW  = 320;
  localparam int SH  = 240;

  typedef struct {
    int q;
    int flagCycles;
  } frame_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [3:0]  quantity;
  logic [31:0] data;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        done;

  logic [31:0] mem [16];
  logic [31:0] rdPipe;

  logic [19:0] expPix[$];
  frame_t      expFrames[$];
  int          idxSeen[$];

  int testsRun   = 0;
  int failCount  = 0;
  int flagCount  = 0;
  int framesDone = 0;
  bit monOn      = 1'b0;

  always #5 clock = ~clock;

  stone_renderer #(
    .SPRITE_SIZE (SZ),
    .RD_LATENCY  (RDL),
    .SCREEN_W    (SW),
    .SCREEN_H    (SH)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .quantity        (quantity),
    .data            (data),
    .draw_stone_flag (draw_stone_flag),
    .draw_index      (draw_index),
    .x               (x),
    .y               (y),
    .colour          (colour),
    .plot            (plot),
    .done            (done)
  );

  // Stone RAM read port: data appears two clocks after the address changes.
  always @(posedge clock) begin
    rdPipe <= mem[draw_index];
    data   <= rdPipe;
  end

  function automatic logic [31:0] makeWord(input int xp, input int yp, input int t,
                                           input int v, input int m);
    logic [31:0] w;
    w        = $urandom;
    w[31:23] = 9'(xp);
    w[18:11] = 8'(yp);
    w[3:2]   = 2'(t);
    w[1]     = 1'(v);
    w[0]     = 1'(m);
    return w;
  endfunction

  function automatic logic [2:0] modelColour(input int t, input int m, input int px, input int py);
    logic [2:0] c;
    case (t)
      0:       c = 3'b111;
      1:       c = 3'b110;
      2:       c = 3'b011;
      default: c = 3'b101;
    endcase
`ifdef MOVING_HIGHLIGHT_EN
    if (m != 0 && (px == 0 || py == 0 || px == SZ - 1 || py == SZ - 1)) c = 3'b100;
`endif
    return c;
  endfunction

  // Frame model: walks the RAM contents and lists every on-screen pixel.
  task automatic buildExpect(input int q);
    frame_t f;
    f.q          = q;
    f.flagCycles = 0;
    for (int i = 0; i < q; i++) begin
      logic [31:0] w;
      int bx, by, t, v, m;
      w  = mem[i];
      bx = int'(w[31:23]);
      by = int'(w[18:11]);
      t  = int'(w[3:2]);
      v  = int'(w[1]);
      m  = int'(w[0]);
      f.flagCycles += 1 + (RDL - 1) + 1 + 1 + (v ? SZ * SZ : 0);
      if (v != 0) begin
        for (int py = 0; py < SZ; py++) begin
          for (int px = 0; px < SZ; px++) begin
            int xx, yy;
            xx = bx + px;
            yy = by + py;
            if (xx < SW && yy < SH) begin
              expPix.push_back({9'(xx), 8'(yy), modelColour(t, m, px, py)});
            end
          end
        end
      end
    end
    expFrames.push_back(f);
  endtask

  // Wait, within a cycle budget, for the monitor to count a finished frame.
  task automatic waitFrame(input int target);
    int cyc;
    cyc = 0;
    while (framesDone < target && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    testsRun++;
    if (framesDone < target) begin
      failCount++;
      $display("[TB] FAIL frame-timeout: frames done %0d, required %0d", framesDone, target);
      expPix.delete();
      expFrames.delete();
    end
  endtask

  // Issue one render request; optionally poke start again while busy.
  task automatic applyStimulus(input int q, input bit poke);
    int target;
    buildExpect(q);
    target = framesDone + 1;
    @(negedge clock);
    quantity = 4'(q);
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    quantity = 4'($urandom);
    if (poke) begin
      repeat (40) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    waitFrame(target);
    repeat (3) @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    testsRun++;
    if (got != want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Monitor: compares every plotted pixel and every done pulse with the model.
  always @(negedge clock) begin
    if (monOn) begin
      if (draw_stone_flag) begin
        flagCount++;
        if (idxSeen.size() == 0 || idxSeen[$] != int'(draw_index)) idxSeen.push_back(int'(draw_index));
      end
      if (plot) begin
        testsRun++;
        if (expPix.size() == 0) begin
          failCount++;
          $display("[TB] FAIL pixel-extra: got x=%0d y=%0d c=%b, required no pixel", x, y, colour);
        end else begin
          logic [19:0] e;
          e = expPix.pop_front();
          if ({x, y, colour} !== e) begin
            failCount++;
            $display("[TB] FAIL pixel: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                     x, y, colour, e[19:11], e[10:3], e[2:0]);
          end
        end
      end
      if (done) begin
        testsRun++;
        if (expFrames.size() == 0) begin
          failCount++;
          $display("[TB] FAIL done-extra: got done pulse, required none");
        end else begin
          frame_t f;
          bit seqOk;
          f = expFrames.pop_front();
          checkOutput("flag-cycles", flagCount, f.flagCycles);
          checkOutput("pixels-left", expPix.size(), 0);
          seqOk = (idxSeen.size() == f.q);
          for (int k = 0; k < idxSeen.size(); k++) if (idxSeen[k] != k) seqOk = 1'b0;
          checkOutput("index-seq-ok", int'(seqOk), 1);
        end
        framesDone++;
        flagCount = 0;
        idxSeen.delete();
      end
    end
  end

  initial begin
    int cyc;
    resetn   = 1'b0;
    start    = 1'b0;
    quantity = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = makeWord(0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset-outputs", int'({draw_stone_flag, draw_index, x, y, colour, plot, done}), 0);
    @(negedge clock);
    resetn = 1'b1;
    monOn  = 1'b1;

    // Single gold item fully on screen.
    mem[0] = makeWord(100, 50, 1, 1, 0);
    applyStimulus(1, 1'b0);

    // Three items, the middle one invisible.
    mem[0] = makeWord(20, 30, 0, 1, 1);
    mem[1] = makeWord(60, 70, 2, 0, 0);
    mem[2] = makeWord(200, 100, 3, 1, 0);
    applyStimulus(3, 1'b0);

    // Clipped at the bottom-right corner, moving stone.
    mem[0] = makeWord(310, 230, 0, 1, 1);
    applyStimulus(1, 1'b0);

    // Empty scan.
    applyStimulus(0, 1'b0);

    // Start while busy must be ignored.
    mem[0] = makeWord(5, 5, 2, 1, 0);
    mem[1] = makeWord(300, 10, 1, 1, 1);
    applyStimulus(2, 1'b1);

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      int q;
      q = $urandom_range(1, 4);
      for (int i = 0; i < q; i++) begin
        mem[i] = makeWord($urandom_range(0, 340), $urandom_range(0, 250), $urandom_range(0, 3),
                          ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1));
      end
      applyStimulus(q, 1'b0);
    end

    // Reset during DRAW of item 2 aborts the frame.
    mem[0] = makeWord(10, 10, 0, 1, 0);
    mem[1] = makeWord(40, 10, 1, 1, 0);
    mem[2] = makeWord(80, 10, 2, 1, 0);
    buildExpect(3);
    @(negedge clock);
    quantity = 4'd3;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc   = 0;
    while (!(plot && draw_index == 4'd2) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("reach-item2-draw", int'(plot && draw_index == 4'd2), 1);
    monOn  = 1'b0;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort-outputs", int'({draw_stone_flag, draw_index, x, y, colour, plot, done}), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("abort-no-done", int'(done), 0);
    end
    expPix.delete();
    expFrames.delete();
    idxSeen.delete();
    flagCount = 0;
    resetn    = 1'b1;
    @(negedge clock);
    monOn = 1'b1;
    applyStimulus(3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
